tpu_job_ctrl: RTL and testbench

Job sequencer that sits between the host memory port and `tpuv1`, and runs one complete matrix job without host involvement. On a `start` pulse it performs these steps in order:
- fetch A, B and optional C operands from a word-addressed source memory;
- issue the matching bus writes into the TPU address map;
- trigger the multiply and wait for the systolic array to drain;
- stream the DIM×DIM C result out over a ready/valid port.

---
 rtl/tpu_pkg.sv | 30 +++
 rtl/tpu_fetch_unit.sv | 41 ++++
 rtl/tpu_job_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_tpu_job_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared constants, state type and sizing helpers for the TPU job sequencer
package tpu_pkg;

    localparam logic [15:0] A_BASE    = 16'h0100;
    localparam logic [15:0] B_BASE    = 16'h0200;
    localparam logic [15:0] C_BASE    = 16'h0300;
    localparam logic [15:0] TRIG_ADDR = 16'h0400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_LOAD_C,
        S_TRIG,
        S_WAIT,
        S_READ,
        S_DONE
    } job_state_t;

    // C words moved per job: the whole DIM x DIM result packed into DATAW-wide words
    function automatic int nc_words(input int dim, input int bits_c, input int dataw);
        return dim * dim * bits_c / dataw;
    endfunction

    // Cycles the systolic array needs to drain after the trigger
    function automatic int wait_cycles(input int dim);
        return 3 * dim;
    endfunction

endpackage

// File: rtl/tpu_fetch_unit.sv
// rtl/tpu_fetch_unit.sv - single-outstanding source memory reader feeding the job FSM
module tpu_fetch_unit #(
    parameter int DATAW  = 64,
    parameter int MADDRW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic [MADDRW-1:0] issue_addr,
    output logic              mem_req,
    output logic [MADDRW-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATAW-1:0]  mem_data,
    output logic              word_valid,
    output logic [DATAW-1:0]  word_data
);

    logic pending;

    // A return only counts while a request is open; stray or post-reset returns fall through
    assign word_valid = pending & mem_valid;
    assign word_data  = mem_data;

    // Registered request pulse and open-request tracking; a new issue wins over a completing return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            pending  <= 1'b0;
        end else begin
            mem_req <= issue;
            if (issue) begin
                mem_addr <= issue_addr;
                pending  <= 1'b1;
            end else if (word_valid) begin
                pending  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tpu_job_ctrl.sv
// rtl/tpu_job_ctrl.sv - runs one load/trigger/drain/readout matrix job on tpuv1
module tpu_job_ctrl
    import tpu_pkg::*;
#(
    parameter int DIM    = 8,
    parameter int BITS_C = 16,
    parameter int DATAW  = 64,
    parameter int ADDRW  = 16,
    parameter int MADDRW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MADDRW-1:0] base,
    input  logic              accum,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [MADDRW-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATAW-1:0]  mem_data,
    output logic              tpu_r_w,
    output logic [ADDRW-1:0]  tpu_addr,
    output logic [DATAW-1:0]  tpu_dataIn,
    input  logic [DATAW-1:0]  tpu_dataOut,
    output logic              res_valid,
    output logic [DATAW-1:0]  res_data,
    input  logic              res_ready
);

    localparam int NC       = nc_words(DIM, BITS_C, DATAW);
    localparam int WAIT_CYC = wait_cycles(DIM);
    localparam int CW       = $clog2(NC) + 1;
    localparam int WW       = $clog2(WAIT_CYC) + 1;

    job_state_t        state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [WW-1:0]     wcnt, wcnt_n;
    logic              rd_phase, rd_phase_n;
    logic [MADDRW-1:0] base_q;
    logic              accum_q;
    logic              take_job;
    logic              issue;
    logic [MADDRW-1:0] issue_idx;
    logic [MADDRW-1:0] issue_addr;
    logic              word_valid;
    logic [DATAW-1:0]  word_data;
    logic              busy_n, done_n, r_w_n, res_valid_n;
    logic [ADDRW-1:0]  addr_n;
    logic [DATAW-1:0]  din_n, res_data_n;

    function automatic logic [ADDRW-1:0] reg_addr(input logic [15:0] region, input logic [CW-1:0] idx);
        return ADDRW'(region) + (ADDRW'(idx) << 3);
    endfunction

    // The very first request of a job uses the base being latched in the same cycle
    assign issue_addr = ((state == S_IDLE) ? base : base_q) + issue_idx;

    tpu_fetch_unit #(
        .DATAW  (DATAW),
        .MADDRW (MADDRW)
    ) u_fetch (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (issue),
        .issue_addr (issue_addr),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // State, counters, job parameters and every output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            wcnt       <= '0;
            rd_phase   <= 1'b0;
            base_q     <= '0;
            accum_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tpu_r_w    <= 1'b0;
            tpu_addr   <= '0;
            tpu_dataIn <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            wcnt       <= wcnt_n;
            rd_phase   <= rd_phase_n;
            busy       <= busy_n;
            done       <= done_n;
            tpu_r_w    <= r_w_n;
            tpu_addr   <= addr_n;
            tpu_dataIn <= din_n;
            res_valid  <= res_valid_n;
            res_data   <= res_data_n;
            if (take_job) begin
                base_q  <= base;
                accum_q <= accum;
            end
        end
    end

    // Next state plus the next value of each registered output; the bus defaults to idle (read of 0x0000)
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        wcnt_n      = wcnt;
        rd_phase_n  = rd_phase;
        take_job    = 1'b0;
        issue       = 1'b0;
        issue_idx   = '0;
        busy_n      = busy;
        done_n      = 1'b0;
        r_w_n       = 1'b0;
        addr_n      = '0;
        din_n       = '0;
        res_valid_n = res_valid;
        res_data_n  = res_data;
        case (state)
            S_IDLE: begin
                if (start) begin
                    take_job = 1'b1;
                    issue    = 1'b1;
                    busy_n   = 1'b1;
                    cnt_n    = '0;
                    state_n  = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                if (word_valid) begin
                    r_w_n = 1'b1;
                    addr_n = reg_addr(A_BASE, cnt);
                    din_n = word_data;
                    issue = 1'b1;
                    if (cnt == CW'(DIM - 1)) begin
                        issue_idx = MADDRW'(DIM);
                        cnt_n     = '0;
                        state_n   = S_LOAD_B;
                    end else begin
                        issue_idx = MADDRW'(cnt) + MADDRW'(1);
                        cnt_n     = cnt + CW'(1);
                    end
                end
            end
            S_LOAD_B: begin
                if (word_valid) begin
                    r_w_n = 1'b1;
                    addr_n = reg_addr(B_BASE, cnt);
                    din_n = word_data;
                    if (cnt == CW'(DIM - 1)) begin
                        issue     = accum_q;
                        issue_idx = MADDRW'(2 * DIM);
                        cnt_n     = '0;
                        state_n   = S_LOAD_C;
                    end else begin
                        issue     = 1'b1;
                        issue_idx = MADDRW'(DIM) + MADDRW'(cnt) + MADDRW'(1);
                        cnt_n     = cnt + CW'(1);
                    end
                end
            end
            S_LOAD_C: begin
                // Without accumulation C is cleared with back-to-back zero writes, no fetches
                if (!accum_q || word_valid) begin
                    r_w_n = 1'b1;
                    addr_n = reg_addr(C_BASE, cnt);
                    din_n = accum_q ? word_data : '0;
                    if (cnt == CW'(NC - 1)) begin
                        cnt_n   = '0;
                        state_n = S_TRIG;
                    end else begin
                        issue     = accum_q;
                        issue_idx = MADDRW'(2 * DIM) + MADDRW'(cnt) + MADDRW'(1);
                        cnt_n     = cnt + CW'(1);
                    end
                end
            end
            S_TRIG: begin
                r_w_n   = 1'b1;
                addr_n  = ADDRW'(TRIG_ADDR);
                wcnt_n  = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // The first WAIT cycle carries the registered trigger write; WAIT_CYC idle cycles follow
                if (wcnt == WW'(WAIT_CYC)) begin
                    addr_n     = reg_addr(C_BASE, '0);
                    cnt_n      = '0;
                    rd_phase_n = 1'b0;
                    state_n    = S_READ;
                end else begin
                    wcnt_n = wcnt + WW'(1);
                end
            end
            S_READ: begin
                if (!rd_phase) begin
                    res_data_n  = tpu_dataOut;
                    res_valid_n = 1'b1;
                    rd_phase_n  = 1'b1;
                end else if (res_ready) begin
                    res_valid_n = 1'b0;
                    rd_phase_n  = 1'b0;
                    if (cnt == CW'(NC - 1)) begin
                        cnt_n   = '0;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = S_DONE;
                    end else begin
                        cnt_n  = cnt + CW'(1);
                        addr_n = reg_addr(C_BASE, cnt + CW'(1));
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tpu_job_ctrl.sv
// tb/tb_tpu_job_ctrl.sv - directed self-checking bench for tpu_job_ctrl
module tb_tpu_job_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base = 16'h0;
    logic        accum = 1'b0;
    logic        busy, done, mem_req, tpu_r_w, res_valid;
    logic [15:0] mem_addr, tpu_addr;
    logic        mem_valid = 1'b0;
    logic [63:0] mem_data = 64'h0;
    logic [63:0] tpu_dataIn, tpu_dataOut, res_data;
    logic        res_ready;
    logic        rand_mode = 1'b0;

    int checks = 0;
    int failures = 0;

    tpu_job_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base        (base),
        .accum       (accum),
        .busy        (busy),
        .done        (done),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data),
        .tpu_r_w     (tpu_r_w),
        .tpu_addr    (tpu_addr),
        .tpu_dataIn  (tpu_dataIn),
        .tpu_dataOut (tpu_dataOut),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] tpu_model(input logic [15:0] a);
        return {a, ~a, a ^ 16'h5a5a, 16'hc0de};
    endfunction

    assign tpu_dataOut = tpu_model(tpu_addr);

    // One-cycle-latency source memory that returns its own address
    always @(posedge clk) begin
        mem_valid <= mem_req;
        mem_data  <= {48'd0, mem_addr};
    end

    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            res_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int          cyc = 0;
    logic [15:0] wr_addr_q[$];
    logic [63:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          rd_cyc_q[$];
    logic [63:0] res_q[$];
    int          req_cnt = 0;
    int          done_cnt = 0;
    logic        hold_pending = 1'b0;
    logic [63:0] held = 64'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending <= 1'b0;
        end else begin
            if (hold_pending) begin
                check("res_hold_valid", 64'(res_valid), 64'd1);
                check("res_hold_data", res_data, held);
            end
            hold_pending <= res_valid && !res_ready;
            held <= res_data;
            if (tpu_r_w) begin
                wr_addr_q.push_back(tpu_addr);
                wr_data_q.push_back(tpu_dataIn);
                wr_cyc_q.push_back(cyc);
            end
            if (!tpu_r_w && tpu_addr != 16'h0) rd_cyc_q.push_back(cyc);
            if (mem_req) req_cnt <= req_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (res_valid && res_ready) res_q.push_back(res_data);
        end
    end

    int s_wr, s_req, s_done, s_res, s_rd;

    task automatic take_snap();
        s_wr = wr_addr_q.size();
        s_req = req_cnt;
        s_done = done_cnt;
        s_res = res_q.size();
        s_rd = rd_cyc_q.size();
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic acc, input logic chk);
        @(negedge clk);
        start = 1'b1;
        base = b;
        accum = acc;
        @(negedge clk);
        start = 1'b0;
        base = 16'hbeef;
        accum = ~acc;
        if (chk) begin
            check("start_busy", 64'(busy), 64'd1);
            check("start_mem_req", 64'(mem_req), 64'd1);
            check("start_mem_addr", 64'(mem_addr), 64'(b));
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 3000);
        check("done_seen", 64'(done), 64'd1);
        check("busy_low_with_done", 64'(busy), 64'd0);
    endtask

    task automatic wait_write(input logic [15:0] a);
        int n = 0;
        while (!(tpu_r_w && tpu_addr == a) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("wait_write", 64'(n < 1000), 64'd1);
    endtask

    task automatic wait_res(input int k);
        int n = 0;
        while ((res_q.size() - s_res) < k && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("wait_res", 64'(n < 1000), 64'd1);
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_ctl"}, {59'd0, busy, done, mem_req, tpu_r_w, res_valid}, 64'd0);
        check({tag, "_addr"}, {32'd0, mem_addr, tpu_addr}, 64'd0);
        check({tag, "_din"}, tpu_dataIn, 64'd0);
        check({tag, "_res"}, res_data, 64'd0);
    endtask

    task automatic verify_job(input logic [15:0] b, input logic acc);
        int          n;
        logic [15:0] ea;
        logic [15:0] w;
        logic [63:0] ed;
        @(negedge clk);
        n = wr_addr_q.size() - s_wr;
        check("wr_count", 64'(n), 64'd33);
        if (n == 33) begin
            for (int i = 0; i < 33; i++) begin
                w = b + 16'(i);
                if (i < 8) begin
                    ea = 16'h0100 + 16'(8 * i);
                    ed = {48'd0, w};
                end else if (i < 16) begin
                    ea = 16'h0200 + 16'(8 * (i - 8));
                    ed = {48'd0, w};
                end else if (i < 32) begin
                    ea = 16'h0300 + 16'(8 * (i - 16));
                    ed = acc ? {48'd0, w} : 64'd0;
                end else begin
                    ea = 16'h0400;
                    ed = 64'd0;
                end
                check($sformatf("wr_addr[%0d]", i), 64'(wr_addr_q[s_wr + i]), 64'(ea));
                check($sformatf("wr_data[%0d]", i), wr_data_q[s_wr + i], ed);
            end
            check("load_beat_cycles", 64'(wr_cyc_q[s_wr + 1] - wr_cyc_q[s_wr]), 64'd2);
            if (!acc) check("zero_c_span", 64'(wr_cyc_q[s_wr + 31] - wr_cyc_q[s_wr + 15]), 64'd16);
            check("trig_follows_c", 64'(wr_cyc_q[s_wr + 32] - wr_cyc_q[s_wr + 31]), 64'd1);
            check("rd_seen", 64'(rd_cyc_q.size() > s_rd), 64'd1);
            if (rd_cyc_q.size() > s_rd)
                check("drain_gap", 64'(rd_cyc_q[s_rd] - wr_cyc_q[s_wr + 32]), 64'd25);
        end
        check("mem_req_count", 64'(req_cnt - s_req), acc ? 64'd32 : 64'd16);
        check("done_pulses", 64'(done_cnt - s_done), 64'd1);
        n = res_q.size() - s_res;
        check("res_count", 64'(n), 64'd16);
        if (n == 16) begin
            for (int k = 0; k < 16; k++)
                check($sformatf("res[%0d]", k), res_q[s_res + k], tpu_model(16'h0300 + 16'(8 * k)));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_outs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        take_snap();
        pulse_start(16'h0040, 1'b1, 1'b1);
        wait_done();
        verify_job(16'h0040, 1'b1);

        take_snap();
        pulse_start(16'h0040, 1'b0, 1'b1);
        wait_done();
        verify_job(16'h0040, 1'b0);

        rand_mode = 1'b1;
        take_snap();
        pulse_start(16'h1234, 1'b1, 1'b1);
        wait_done();
        verify_job(16'h1234, 1'b1);
        rand_mode = 1'b0;

        take_snap();
        pulse_start(16'h0040, 1'b1, 1'b1);
        wait_write(16'h0208);
        pulse_start(16'h0080, 1'b0, 1'b0);
        wait_done();
        verify_job(16'h0040, 1'b1);

        take_snap();
        pulse_start(16'h0040, 1'b1, 1'b0);
        wait_write(16'h0400);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outs_zero("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        take_snap();
        pulse_start(16'hfff8, 1'b0, 1'b1);
        wait_done();
        verify_job(16'hfff8, 1'b0);

        rand_mode = 1'b1;
        take_snap();
        pulse_start(16'h0100, 1'b1, 1'b0);
        wait_res(3);
        #2 rst_n = 1'b0;
        #1 check_outs_zero("rst_read");
        rand_mode = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        take_snap();
        pulse_start(16'hfff8, 1'b1, 1'b1);
        wait_done();
        verify_job(16'hfff8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
